conv_sched: RTL and testbench
=============================

# conv_sched

Sequencing controller for one streaming convolution layer (`conv_layer`-style datapath). On `start` it:
- clears the datapath;
- loads the k×k weight set from a ready/valid stream;
- streams the n×n activation map from a 1-cycle-latency read port into the datapath;
- writes each valid convolution result to an output buffer, then reports `done` or `error`.

It sits between the layer-level sequencer and the datapath / activation / output memories.

## Interface
- `activation_map`, 10: n, side of the square input map.
- `kernel`, 3: k, side of the square kernel.
- `stride`, 1: s; only used to compute the expected output count.
- `total_bits`, 16: data word width.
- `fraction_bits`, 12: fixed-point fraction bits; passed through, not used arithmetically.
- `addr_bits`, 16: width of the activation and output addresses.
- `drain_cycles`, 4: number of post-stream flush cycles.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE.
- `start`  in  1  one-cycle request; sampled in IDLE only.
- `weight_in`  in  total_bits  weight word.
- `weight_in_valid`  in  1  weight word valid.
- `weight_in_ready`  out  1  weight word accepted when valid&ready.
- `act_rd_en`  out  1  activation read request.
- `act_rd_addr`  out  addr_bits  activation read address.
- `act_rd_data`  in  total_bits  read data, valid exactly 1 cycle after `act_rd_en`.
- `conv_reset`  out  1  datapath synchronous clear.
- `conv_calculate`  out  1  datapath clock enable.
- `conv_activation`  out  total_bits  datapath activation input.
- `conv_weight`  out  k*k*16  packed weights; word i occupies [16i +: 16].
- `conv_op`  in  total_bits  datapath result.
- `conv_valid`  in  1  datapath result valid.
- `out_wr_en`  out  1  output buffer write strobe.
- `out_wr_addr`  out  addr_bits  output buffer address.
- `out_wr_data`  out  total_bits  output buffer data.
- `busy`  out  1  high from CLEAR through DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky; set when fewer results than expected arrived.

## Operation
- Expected output count: OUT_N = ((n−k)/s+1)², integer division; 64 at the defaults.
- States: IDLE → CLEAR → LOAD_W → STREAM → DRAIN → DONE → IDLE.
- **IDLE**
  - `start`=1 → CLEAR.
  - `error` is cleared on this transition; otherwise `error` holds its value.
- **CLEAR:** one cycle; `conv_reset`=1; weight index, read address, delay flag and result count zeroed.
- **LOAD_W:**
  - `weight_in_ready`=1.
  - Each valid&ready handshake writes `weight_in` to word[idx], then idx++.
  - On the k·k-th handshake → STREAM.
  - `conv_weight` holds its value until the next load and is not cleared by `start`.
- **STREAM:**
  - `act_rd_en`=1 every cycle, `act_rd_addr`=0,1,…,n²−1.
  - After the read at address n²−1 is issued → DRAIN.
  - A registered copy of `act_rd_en` (`d_en`) drives `conv_calculate`.
  - `conv_activation` = `act_rd_data` when `d_en`=1, else 0.
- **DRAIN:**
  - First cycle: delivers the last activation (`d_en`=1).
  - Then `conv_calculate`=1 with `conv_activation`=0 for `drain_cycles` cycles.
  - Exits early to DONE when the result count reaches OUT_N.
  - If the count is still < OUT_N after the last drain cycle: `error`←1, → DONE.
- **Result capture (STREAM and DRAIN only):**
  - When `conv_valid`=1 and count<OUT_N: registered write with `out_wr_en`=1, `out_wr_addr`=count, `out_wr_data`=`conv_op`; count++.
  - A `conv_valid` arriving when count=OUT_N is dropped with no write.
  - `conv_valid` in any other state is ignored.
- **DONE:** `done`=1 for one cycle, `busy`=0 → IDLE.
- `start` outside IDLE is ignored; there is no queuing.

## Timing
- Reset values: `weight_in_ready`, `act_rd_en`, `conv_reset`, `conv_calculate`, `busy`, `done`, `error`, `out_wr_en` all 0; all addresses and data 0; `conv_weight` 0; state IDLE.
- Cycle numbering from `start` sampled high at edge t:
  - t+1: CLEAR.
  - t+2: LOAD_W begins.
  - Minimum LOAD_W length is k·k cycles.
- STREAM lasts exactly n² cycles.
- `conv_calculate` is high for n² + `drain_cycles` cycles total, unless DRAIN exits early.
- `out_wr_*` lags `conv_valid` by 1 cycle.
- The final write and `done` may coincide; `done` is asserted the cycle after the state registers the count reaching OUT_N.
- Reset mid-operation:
  - All outputs return to their reset values asynchronously, including any in-flight write strobe.
  - The next `start` performs a full CLEAR.
- Simultaneous weight handshake and state exit: the k·k-th word is stored in the same edge as the transition.

## Test plan
- **Nominal:** n=10, k=3, s=1; weights 0x1000 (1.0); activation[a]=a. → 9 handshakes; 100 reads at addresses 0..99; 64 writes at addresses 0..63; `done` pulse; `error`=0.
- **Weight backpressure:** `weight_in_valid` toggles 1/0. → exactly 9 words captured, in order; STREAM starts the cycle after the 9th handshake; `act_rd_en` never high in LOAD_W.
- **Start while busy:** `start` pulsed in STREAM. → no restart; read address sequence unbroken; single `done`.
- **Reset mid-STREAM** at address 40. → all outputs 0 immediately; IDLE; a new `start` reloads weights and reads from address 0.
- **Under-delivery:** datapath stub asserts only 60 valids. → 60 writes; `error`=1 after 4 drain cycles; `done` pulses; `error` is cleared by the next `start`.
- **Over-delivery:** stub asserts 70 valids. → exactly 64 writes; addresses never exceed 63; `error`=0.

Source files
------------

// File: rtl/conv_sched.sv
// conv_sched: sequencing controller for one streaming convolution layer.
//
// After a one-cycle start request in IDLE the controller:
//   1. clears the datapath (CLEAR, conv_reset pulse),
//   2. collects kernel*kernel weight words from a ready/valid stream (LOAD_W),
//   3. reads the activation_map^2 activations from a 1-cycle-latency memory
//      and feeds them to the datapath (STREAM),
//   4. flushes the datapath pipeline for drain_cycles cycles (DRAIN),
//   5. pulses done (DONE) and returns to IDLE.
// Every datapath result seen in STREAM/DRAIN is written to the output buffer
// at consecutive addresses until the expected output count is reached.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   start                      one-cycle request, honoured in IDLE only
//   weight_in/_valid/_ready    weight stream (word accepted on valid & ready)
//   act_rd_en/_addr/_data      activation read port, data one cycle after en
//   conv_reset                 datapath synchronous clear
//   conv_calculate             datapath clock enable
//   conv_activation            datapath activation input (0 while flushing)
//   conv_weight                packed weights, word i at [total_bits*i +: total_bits]
//   conv_op, conv_valid        datapath result and its valid
//   out_wr_en/_addr/_data      output buffer write port
//   busy                       high from CLEAR through DRAIN
//   done                       one-cycle completion pulse
//   error                      sticky: fewer results than expected arrived
module conv_sched #(
  parameter int activation_map = 10,
  parameter int kernel         = 3,
  parameter int stride         = 1,
  parameter int total_bits     = 16,
  parameter int fraction_bits  = 12,
  parameter int addr_bits      = 16,
  parameter int drain_cycles   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [total_bits-1:0]                weight_in,
  input  logic                                 weight_in_valid,
  output logic                                 weight_in_ready,
  output logic                                 act_rd_en,
  output logic [addr_bits-1:0]                 act_rd_addr,
  input  logic [total_bits-1:0]                act_rd_data,
  output logic                                 conv_reset,
  output logic                                 conv_calculate,
  output logic [total_bits-1:0]                conv_activation,
  output logic [kernel*kernel*total_bits-1:0]  conv_weight,
  input  logic [total_bits-1:0]                conv_op,
  input  logic                                 conv_valid,
  output logic                                 out_wr_en,
  output logic [addr_bits-1:0]                 out_wr_addr,
  output logic [total_bits-1:0]                out_wr_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);

  localparam int KK       = kernel * kernel;
  localparam int N2       = activation_map * activation_map;
  localparam int OUT_SIDE = (activation_map - kernel) / stride + 1;
  localparam int OUT_N    = OUT_SIDE * OUT_SIDE;
  localparam int WI_W     = $clog2(KK + 1);
  localparam int DC_W     = (drain_cycles > 0) ? $clog2(drain_cycles + 1) : 1;
  localparam int WGT_W    = KK * total_bits;

  localparam logic [addr_bits-1:0] LAST_ADDR  = addr_bits'(N2 - 1);
  localparam logic [addr_bits-1:0] OUT_N_A    = addr_bits'(OUT_N);
  localparam logic [WI_W-1:0]      LAST_WI    = WI_W'(KK - 1);
  localparam logic [DC_W-1:0]      DRAIN_LAST = DC_W'(drain_cycles);

  // Parameter sanity: a kernel wider than the map has no valid output, and
  // the fixed-point format needs at least one integer (sign) bit.
  if (kernel > activation_map) begin : g_bad_kernel
    $error("conv_sched: kernel must not exceed activation_map");
  end
  if (fraction_bits >= total_bits) begin : g_bad_frac
    $error("conv_sched: fraction_bits must be smaller than total_bits");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WI_W-1:0]      widx_q, widx_d;
  logic [addr_bits-1:0] rd_addr_q, rd_addr_d;
  logic [addr_bits-1:0] cnt_q, cnt_d;
  logic [DC_W-1:0]      drain_q, drain_d;
  logic [WGT_W-1:0]     weight_q, weight_d;
  logic                 d_en_q, d_en_d;
  logic                 ready_q, ready_d;
  logic                 rd_en_q, rd_en_d;
  logic                 clr_q, clr_d;
  logic                 calc_q, calc_d;
  logic                 wr_en_q, wr_en_d;
  logic [addr_bits-1:0] wr_addr_q, wr_addr_d;
  logic [total_bits-1:0] wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    weight_d  = weight_q;
    error_d   = error_q;
    // The read data arrives one cycle after the request, so the datapath
    // enable is the request delayed by one cycle.
    d_en_d    = rd_en_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // Result capture; results past the expected count are dropped.
    if ((state_q == S_STREAM || state_q == S_DRAIN) && conv_valid && (cnt_q < OUT_N_A)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = cnt_q;
      wr_data_d = conv_op;
      cnt_d     = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          error_d = 1'b0;
        end
      end
      S_CLEAR: begin
        widx_d    = '0;
        rd_addr_d = '0;
        cnt_d     = '0;
        drain_d   = '0;
        d_en_d    = 1'b0;
        state_d   = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (weight_in_valid && ready_q) begin
          for (int i = 0; i < KK; i++) begin
            if (widx_q == WI_W'(i)) begin
              weight_d[i*total_bits +: total_bits] = weight_in;
            end
          end
          widx_d = widx_q + 1'b1;
          if (widx_q == LAST_WI) begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // cnt_d includes a result captured on this same edge, so the final
        // write and done can land in the same cycle.
        if (cnt_d == OUT_N_A) begin
          state_d = S_DONE;
        end else if (drain_q == DRAIN_LAST) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered and decoded from the next state so they line
    // up with the state they belong to.
    ready_d = (state_d == S_LOAD_W);
    rd_en_d = (state_d == S_STREAM);
    clr_d   = (state_d == S_CLEAR);
    // The first DRAIN cycle still carries the last activation (d_en); the
    // remaining DRAIN cycles clock zeros through the pipeline.
    calc_d  = d_en_d || (state_d == S_DRAIN);
    busy_d  = (state_d == S_CLEAR) || (state_d == S_LOAD_W) ||
              (state_d == S_STREAM) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      widx_q    <= '0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
      drain_q   <= '0;
      weight_q  <= '0;
      d_en_q    <= 1'b0;
      ready_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      clr_q     <= 1'b0;
      calc_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      widx_q    <= widx_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      weight_q  <= weight_d;
      d_en_q    <= d_en_d;
      ready_q   <= ready_d;
      rd_en_q   <= rd_en_d;
      clr_q     <= clr_d;
      calc_q    <= calc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign weight_in_ready = ready_q;
  assign act_rd_en       = rd_en_q;
  assign act_rd_addr     = rd_addr_q;
  assign conv_reset      = clr_q;
  assign conv_calculate  = calc_q;
  assign conv_activation = d_en_q ? act_rd_data : '0;
  assign conv_weight     = weight_q;
  assign out_wr_en       = wr_en_q;
  assign out_wr_addr     = wr_addr_q;
  assign out_wr_data     = wr_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_conv_sched.sv
`timescale 1ns/1ps
module tb_conv_sched;

  localparam int KK    = 9;
  localparam int N2    = 100;
  localparam int OUT_N = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [15:0]       weight_in;
  logic              weight_in_valid;
  logic              weight_in_ready;
  logic              act_rd_en;
  logic [15:0]       act_rd_addr;
  logic [15:0]       act_rd_data;
  logic              conv_reset;
  logic              conv_calculate;
  logic [15:0]       conv_activation;
  logic [KK*16-1:0]  conv_weight;
  logic [15:0]       conv_op;
  logic              conv_valid;
  logic              out_wr_en;
  logic [15:0]       out_wr_addr;
  logic [15:0]       out_wr_data;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  conv_sched dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .weight_in       (weight_in),
    .weight_in_valid (weight_in_valid),
    .weight_in_ready (weight_in_ready),
    .act_rd_en       (act_rd_en),
    .act_rd_addr     (act_rd_addr),
    .act_rd_data     (act_rd_data),
    .conv_reset      (conv_reset),
    .conv_calculate  (conv_calculate),
    .conv_activation (conv_activation),
    .conv_weight     (conv_weight),
    .conv_op         (conv_op),
    .conv_valid      (conv_valid),
    .out_wr_en       (out_wr_en),
    .out_wr_addr     (out_wr_addr),
    .out_wr_data     (out_wr_data),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  typedef struct {
    int bp;          // weight_in_valid toggles 1/0
    int vstart;      // conv_calculate cycle index of the first datapath valid
    int nvalid;      // number of datapath valids the stub produces
    int start_busy;  // pulse start again while streaming address 40
    int exp_writes;
    int exp_err;
    int exp_calc;    // total conv_calculate cycles
  } vec_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  vec_t tbl [6];
  wr_t  sb_q [$];
  int   checks = 0;
  int   failures = 0;
  int   exp_err_idle = 0;

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One complete layer run; abort_addr >= 0 asserts reset while that
  // activation address is being read.
  task automatic run(input int sc, input vec_t v, input int abort_addr);
    logic [15:0]      w [KK];
    logic [KK*16-1:0] w_exp;
    logic [15:0]      prev_addr;
    logic [15:0]      exp_act;
    logic             prev_en;
    wr_t              e;
    string            p;
    int wi, hs, last_hs, first_rd, rd_cnt, rd_bad, ovl;
    int calc_idx, act_bad, writes, done_cnt, model_cnt, tail;
    bit finished, aborted;

    p = $sformatf("s%0d_", sc);
    for (int i = 0; i < KK; i++) begin
      w[i] = 16'(32'h1000 + sc * 16 + i);
      w_exp[i*16 +: 16] = w[i];
    end
    wi = 0; hs = 0; last_hs = -100; first_rd = -1; rd_cnt = 0; rd_bad = 0; ovl = 0;
    calc_idx = 0; act_bad = 0; writes = 0; done_cnt = 0; model_cnt = 0; tail = 0;
    finished = 1'b0; aborted = 1'b0;
    prev_en = 1'b0; prev_addr = '0;
    sb_q.delete();

    for (int s = 0; s < 700; s++) begin
      // Registered outputs of cycle s
      if (s == 0) check_i({p, "idle_error"}, int'(error), exp_err_idle);
      if (s == 1) begin
        check_i({p, "clear_pulse"}, int'(conv_reset), 1);
        check_i({p, "clear_busy"}, int'(busy), 1);
        check_i({p, "error_cleared"}, int'(error), 0);
      end
      if (s == 2) check_i({p, "load_ready"}, int'(weight_in_ready), 1);
      if (act_rd_en && weight_in_ready) ovl++;
      if (act_rd_en) begin
        if (first_rd < 0) first_rd = s;
        if (act_rd_addr != 16'(rd_cnt)) rd_bad++;
        rd_cnt++;
      end
      if (out_wr_en) begin
        writes++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_v({p, "write"}, 160'({out_wr_addr, out_wr_data}), 160'(e));
        end
      end
      if (done) begin
        done_cnt++;
        if (!finished) begin
          finished = 1'b1;
          check_i({p, "done_busy"}, int'(busy), 0);
          check_i({p, "done_error"}, int'(error), v.exp_err);
        end
      end

      if (abort_addr >= 0 && act_rd_en && act_rd_addr == 16'(abort_addr)) begin
        check_i({p, "pre_rst_wr_en"}, int'(out_wr_en), 1);
        reset = 1'b1;
        #1;
        check_i({p, "rst_rd_en"}, int'(act_rd_en), 0);
        check_i({p, "rst_wr_en"}, int'(out_wr_en), 0);
        check_v({p, "rst_ctrl"},
                160'({weight_in_ready, conv_reset, conv_calculate, busy, done, error}), '0);
        check_v({p, "rst_data"},
                160'({act_rd_addr, out_wr_addr, out_wr_data, conv_activation}), '0);
        check_v({p, "rst_weights"}, 160'(conv_weight), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        conv_valid = 1'b0;
        weight_in_valid = 1'b0;
        sb_q.delete();
        exp_err_idle = 0;
        aborted = 1'b1;
        break;
      end

      // Inputs for cycle s: memory model, weight source, datapath stub
      act_rd_data = prev_en ? prev_addr : 16'hDEAD;
      prev_en = act_rd_en;
      prev_addr = act_rd_addr;
      start = (s == 0) || (v.start_busy != 0 && act_rd_en && act_rd_addr == 16'd40);
      weight_in_valid = (v.bp != 0) ? (s % 2 == 0) : 1'b1;
      weight_in = w[(wi < KK) ? wi : KK - 1];
      if (weight_in_valid && weight_in_ready) begin
        hs++;
        last_hs = s;
        wi++;
      end
      conv_valid = conv_calculate && (calc_idx >= v.vstart) && (calc_idx < v.vstart + v.nvalid);
      conv_op = conv_valid ? 16'(calc_idx * 7 + 3) : 16'h0;
      if (conv_valid && model_cnt < OUT_N) begin
        sb_q.push_back({16'(model_cnt), conv_op});
        model_cnt++;
      end
      #1;
      exp_act = (conv_calculate && calc_idx < N2) ? 16'(calc_idx) : 16'h0;
      if (conv_activation !== exp_act) act_bad++;
      if (conv_calculate) calc_idx++;
      if (finished) tail++;
      if (tail == 6) break;
      @(posedge clk);
      #1;
    end

    start = 1'b0;
    conv_valid = 1'b0;
    if (!aborted) begin
      check_i({p, "done_count"}, done_cnt, 1);
      check_i({p, "writes"}, writes, v.exp_writes);
      check_i({p, "sb_left"}, sb_q.size(), 0);
      check_i({p, "handshakes"}, hs, KK);
      check_i({p, "stream_start"}, first_rd, last_hs + 1);
      check_i({p, "reads"}, rd_cnt, N2);
      check_i({p, "read_order_bad"}, rd_bad, 0);
      check_i({p, "rd_in_load"}, ovl, 0);
      check_i({p, "calc_cycles"}, calc_idx, v.exp_calc);
      check_i({p, "activation_bad"}, act_bad, 0);
      check_v({p, "weights"}, 160'(conv_weight), 160'(w_exp));
      check_i({p, "error_sticky"}, int'(error), v.exp_err);
      exp_err_idle = v.exp_err;
    end
  endtask

  initial begin
    vec_t rv;
    //           bp vst nv  sb wr err calc
    tbl[0] = '{0, 36, 64, 0, 64, 0, 100};   // nominal, done with last write
    tbl[1] = '{1, 36, 64, 0, 64, 0, 100};   // weight backpressure
    tbl[2] = '{0, 36, 64, 1, 64, 0, 100};   // start while streaming
    tbl[3] = '{0, 20, 60, 0, 60, 1, 104};   // under-delivery, full drain
    tbl[4] = '{0, 36, 64, 0, 64, 0, 100};   // error cleared by next start
    tbl[5] = '{0, 20, 70, 0, 64, 0, 100};   // over-delivery

    reset = 1'b1;
    start = 1'b0;
    weight_in = '0;
    weight_in_valid = 1'b0;
    act_rd_data = '0;
    conv_op = '0;
    conv_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_v("reset_ctrl", 160'({weight_in_ready, act_rd_en, conv_reset, conv_calculate,
                                busy, done, error, out_wr_en}), '0);
    check_v("reset_data", 160'({act_rd_addr, out_wr_addr, out_wr_data, conv_activation}), '0);
    check_v("reset_weights", 160'(conv_weight), '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_i("idle_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) run(i, tbl[i], -1);

    // Reset in the middle of STREAM, then a full restart
    rv = tbl[0];
    rv.vstart = 20;
    run(6, rv, 40);
    check_i("post_rst_busy", int'(busy), 0);
    run(7, tbl[0], -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
